multi_game_timer: RTL and testbench
===================================

MULTI_GAME_TIMER -- requirements
Module: multi_game_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, counter width per channel.
REQ-002 SHALL have parameter N_CH, default 4, number of independent timer channels (1..16).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port value  input  WIDTH  shared load value, sampled by any channel whose start bit is high.
REQ-006 SHALL have port start  input  N_CH  per-channel start/restart request.
REQ-007 SHALL have port stop  input  N_CH  per-channel abort request.
REQ-008 SHALL have port periodic  input  N_CH  per-channel mode, sampled with start: 0 one-shot, 1 auto-reload.
REQ-009 SHALL have port running  output  N_CH  per-channel active flag.
REQ-010 SHALL have port expired  output  N_CH  per-channel one-cycle pulse on terminal count.
REQ-011 SHALL have port any_running  output  1  OR of running.

Function
REQ-012 On start[i], channel i SHALL load counter and reload register with value, latch periodic[i], and set running[i] the next cycle.
REQ-013 While running[i] and counter nonzero, counter SHALL decrement by 1 per cycle, unsigned, no wrap.
REQ-014 When running[i] and counter equals 0, expired[i] SHALL pulse high for exactly that next cycle; one-shot clears running[i]; periodic reloads counter from reload register and keeps running[i].
REQ-015 One-shot: running[i] SHALL be high for exactly value+1 cycles; value 0 gives 1 cycle of running and expired one cycle later.
REQ-016 Periodic: expired[i] SHALL pulse every value+1 cycles until stopped.
REQ-017 start[i] on an idle or running channel SHALL restart it; start coinciding with terminal count SHALL win with no expired pulse.
REQ-018 stop[i] SHALL clear running[i] next cycle without an expired pulse; stop and start same cycle: stop wins.
REQ-019 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.
REQ-020 expired and running SHALL be registered outputs; any_running MAY be combinational from running.

Reset
REQ-021 reset SHALL clear running, expired, and latched mode of every channel, and zero counter and reload registers; reset overrides start and stop.
REQ-022 reset asserted mid-count SHALL abort all channels with no expired pulse.

Configuration
REQ-023 With GAME_TIMER_PAUSE_EN defined, the module SHALL add port pause  input  1; while pause is high all counters hold, no expired pulses fire, start/stop/reset still act.
REQ-024 Without GAME_TIMER_PAUSE_EN the pause port SHALL be absent and counters never hold.

Structure
REQ-025 Package game_timer_pkg SHALL hold the channel mode enum (ONE_SHOT, PERIODIC) and default WIDTH/N_CH constants.
REQ-026 Per-channel logic SHALL be sub-module game_timer_channel, instantiated N_CH times via generate.

Verification
REQ-027 Start ch0 one-shot, value=5 -> running[0] high 6 cycles, expired[0] single pulse after the last running cycle, others idle.
REQ-028 Start ch1 periodic, value=3 -> expired[1] pulses every 4 cycles for 3 periods; stop -> running[1] low next cycle, no further pulses.
REQ-029 Start ch2 value=0 -> running 1 cycle, expired 1 pulse; restart ch2 value=10 on its terminal cycle -> no pulse, 11 further running cycles.
REQ-030 start and stop same cycle on ch3 -> ch3 stays idle; simultaneous start on ch0 and ch3 with value=7 -> both expire on same cycle.
REQ-031 reset asserted 4 cycles into value=20 on all channels -> all running, expired and any_running low next cycle, no pulses.
REQ-032 With GAME_TIMER_PAUSE_EN, value=8, pause high 5 cycles mid-count -> expiry delayed exactly 5 cycles.

Source files
------------

// File: rtl/game_timer_pkg.sv
// rtl/game_timer_pkg.sv - shared channel mode type and default sizing for multi_game_timer
package game_timer_pkg;

    typedef enum logic {
        ONE_SHOT = 1'b0,
        PERIODIC = 1'b1
    } mode_e;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_N_CH  = 4;

endpackage

// File: rtl/game_timer_channel.sv
// rtl/game_timer_channel.sv - one down-counting timer channel with one-shot/auto-reload modes
module game_timer_channel
    import game_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic [WIDTH-1:0] value,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    output logic             running,
    output logic             expired
);

    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] reload;
    mode_e            mode;

    // Priority: reset, then stop, then start; a start on the terminal cycle
    // therefore suppresses that cycle's expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
            reload  <= '0;
            mode    <= ONE_SHOT;
            running <= 1'b0;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (stop) begin
                running <= 1'b0;
            end else if (start) begin
                counter <= value;
                reload  <= value;
                mode    <= periodic ? PERIODIC : ONE_SHOT;
                running <= 1'b1;
            end else if (running && !hold) begin
                if (counter == '0) begin
                    expired <= 1'b1;
                    if (mode == PERIODIC) begin
                        counter <= reload;
                    end else begin
                        running <= 1'b0;
                    end
                end else begin
                    counter <= counter - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/multi_game_timer.sv
// rtl/multi_game_timer.sv - N_CH independent game timers sharing one load value
// Optional GAME_TIMER_PAUSE_EN adds a global pause input that freezes all counters.
module multi_game_timer
    import game_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N_CH  = DEFAULT_N_CH
) (
    input  logic             clk,
    input  logic             reset,
`ifdef GAME_TIMER_PAUSE_EN
    input  logic             pause,
`endif
    input  logic [WIDTH-1:0] value,
    input  logic [N_CH-1:0]  start,
    input  logic [N_CH-1:0]  stop,
    input  logic [N_CH-1:0]  periodic,
    output logic [N_CH-1:0]  running,
    output logic [N_CH-1:0]  expired,
    output logic             any_running
);

    logic hold;

`ifdef GAME_TIMER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        game_timer_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .hold    (hold),
            .value   (value),
            .start   (start[i]),
            .stop    (stop[i]),
            .periodic(periodic[i]),
            .running (running[i]),
            .expired (expired[i])
        );
    end

    assign any_running = |running;

endmodule

// File: tb/tb_multi_game_timer.sv
// tb/tb_multi_game_timer.sv - self-checking bench for multi_game_timer against an age-based timer model
module tb_multi_game_timer;

    localparam int W = 16;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         pause;
    logic [W-1:0] value;
    logic [N-1:0] start, stop, periodic;
    logic [N-1:0] running, expired;
    logic         any_running;

    int checks   = 0;
    int failures = 0;
    longint cyc  = 0;

    // Model: a channel is active from its start edge; its age counts unpaused
    // edges since start, and every (v+1)-th age is an expiry.
    bit     m_act[N];
    bit     m_per[N];
    longint m_v[N];
    longint m_age[N];
    logic [N-1:0] exp_run, exp_exp;

    multi_game_timer #(.WIDTH(W), .N_CH(N)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef GAME_TIMER_PAUSE_EN
        .pause      (pause),
`endif
        .value      (value),
        .start      (start),
        .stop       (stop),
        .periodic   (periodic),
        .running    (running),
        .expired    (expired),
        .any_running(any_running)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        cyc++;
        exp_exp = '0;
        for (int i = 0; i < N; i++) begin
            if (reset || stop[i]) begin
                m_act[i] = 1'b0;
            end else if (start[i]) begin
                m_act[i] = 1'b1;
                m_per[i] = periodic[i];
                m_v[i]   = longint'(value);
                m_age[i] = 0;
            end else if (m_act[i] && !pause) begin
                m_age[i]++;
                if (m_age[i] % (m_v[i] + 1) == 0) begin
                    exp_exp[i] = 1'b1;
                    if (!m_per[i]) m_act[i] = 1'b0;
                end
            end
            exp_run[i] = m_act[i];
        end
        #1;
    endtask

    task automatic idle_inputs();
        start = '0; stop = '0; periodic = '0; reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = '1; stop = '0; periodic = '1; value = 16'd3; pause = 1'b0;
        tick();
        tick();
        checks++;
        if ({running, expired, any_running} !== '0) begin
            failures++;
            $display("FAIL reset_state running=%b expired=%b any=%b required all 0", running, expired, any_running);
        end
        idle_inputs();
        tick();
        checks++;
        if ({running, expired, any_running} !== '0) begin
            failures++;
            $display("FAIL reset_idle running=%b expired=%b any=%b required all 0", running, expired, any_running);
        end
    endtask

    task automatic test_one_shot();
        int run_cnt = 0, exp_cnt = 0, other = 0, bad = 0;
        int exp_at = -1;
        value = 16'd5; start = 4'b0001;
        tick();
        idle_inputs();
        for (int k = 0; k < 10; k++) begin
            run_cnt += int'(running[0]);
            if (expired[0]) begin exp_cnt++; exp_at = k; end
            other += int'(|running[N-1:1]) + int'(|expired[N-1:1]);
            if ({running, expired, any_running} !== {exp_run, exp_exp, |exp_run}) bad++;
            tick();
        end
        checks++;
        if (run_cnt != 6 || exp_cnt != 1 || exp_at != 6 || other != 0 || bad != 0) begin
            failures++;
            $display("FAIL one_shot run=%0d exp=%0d at=%0d other=%0d modelbad=%0d required 6 1 6 0 0",
                     run_cnt, exp_cnt, exp_at, other, bad);
        end
    endtask

    task automatic test_periodic();
        int pulses = 0, last = -1, gap_bad = 0;
        value = 16'd3; start = 4'b0010; periodic = 4'b0010;
        tick();
        idle_inputs();
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (expired[1]) begin
                if (last >= 0 && k - last != 4) gap_bad++;
                last = k;
                pulses++;
            end
        end
        checks++;
        if (pulses != 3 || gap_bad != 0 || last != 12) begin
            failures++;
            $display("FAIL periodic pulses=%0d gapbad=%0d last=%0d required 3 0 12", pulses, gap_bad, last);
        end
        stop = 4'b0010;
        tick();
        idle_inputs();
        checks++;
        if (running[1] !== 1'b0 || expired[1] !== 1'b0) begin
            failures++;
            $display("FAIL periodic_stop running1=%b expired1=%b required 0 0", running[1], expired[1]);
        end
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            pulses += int'(expired[1]) + int'(running[1]);
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL periodic_after_stop activity=%0d required 0", pulses);
        end
    endtask

    task automatic test_restart();
        int run_cnt, exp_cnt = 0;
        value = 16'd0; start = 4'b0100;
        tick();
        idle_inputs();
        checks++;
        if (running[2] !== 1'b1 || expired[2] !== 1'b0) begin
            failures++;
            $display("FAIL zero_value_run running2=%b expired2=%b required 1 0", running[2], expired[2]);
        end
        tick();
        checks++;
        if (running[2] !== 1'b0 || expired[2] !== 1'b1) begin
            failures++;
            $display("FAIL zero_value_expire running2=%b expired2=%b required 0 1", running[2], expired[2]);
        end
        value = 16'd0; start = 4'b0100;
        tick();
        value = 16'd10;
        tick();
        idle_inputs();
        run_cnt = int'(running[2]);
        exp_cnt = int'(expired[2]);
        for (int k = 0; k < 14; k++) begin
            tick();
            run_cnt += int'(running[2]);
            if (k < 10) exp_cnt += int'(expired[2]);
        end
        checks++;
        if (run_cnt != 11 || exp_cnt != 0) begin
            failures++;
            $display("FAIL restart_on_terminal run=%0d early_exp=%0d required 11 0", run_cnt, exp_cnt);
        end
    endtask

    task automatic test_start_stop();
        int at0 = -1, at3 = -1;
        value = 16'd4; start = 4'b1000; stop = 4'b1000;
        tick();
        idle_inputs();
        checks++;
        if (running[3] !== 1'b0 || any_running !== 1'b0) begin
            failures++;
            $display("FAIL start_stop_same running3=%b any=%b required 0 0", running[3], any_running);
        end
        value = 16'd7; start = 4'b1001;
        tick();
        idle_inputs();
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (expired[0] && at0 < 0) at0 = k;
            if (expired[3] && at3 < 0) at3 = k;
        end
        checks++;
        if (at0 != 8 || at3 != 8) begin
            failures++;
            $display("FAIL simultaneous_expire ch0_at=%0d ch3_at=%0d required 8 8", at0, at3);
        end
    endtask

    task automatic test_reset_mid();
        int act = 0;
        value = 16'd20; start = '1; periodic = 4'b0101;
        tick();
        idle_inputs();
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({running, expired, any_running} !== '0) begin
            failures++;
            $display("FAIL reset_mid running=%b expired=%b any=%b required all 0", running, expired, any_running);
        end
        for (int k = 0; k < 25; k++) begin
            tick();
            act += int'(|expired) + int'(|running);
        end
        checks++;
        if (act != 0) begin
            failures++;
            $display("FAIL reset_mid_after activity=%0d required 0", act);
        end
    endtask

`ifdef GAME_TIMER_PAUSE_EN
    task automatic test_pause();
        int at = -1;
        value = 16'd8; start = 4'b0001;
        tick();
        idle_inputs();
        for (int k = 1; k <= 20; k++) begin
            pause = (k >= 3 && k < 8);
            tick();
            if (expired[0] && at < 0) at = k;
        end
        pause = 1'b0;
        checks++;
        if (at != 14) begin
            failures++;
            $display("FAIL pause_delay expire_at=%0d required 14", at);
        end
    endtask
`endif

    task automatic test_random();
        int bad = 0;
        for (int k = 0; k < 400; k++) begin
            value    = W'($urandom_range(0, 6));
            start    = N'($urandom) & N'($urandom) & N'($urandom);
            stop     = N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom);
            periodic = N'($urandom);
            reset    = ($urandom_range(0, 99) == 0);
`ifdef GAME_TIMER_PAUSE_EN
            pause    = ($urandom_range(0, 4) == 0);
`endif
            tick();
            checks++;
            if ({running, expired, any_running} !== {exp_run, exp_exp, |exp_run}) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random cyc=%0d running=%b/%b expired=%b/%b any=%b/%b (actual/required)",
                             cyc, running, exp_run, expired, exp_exp, any_running, |exp_run);
            end
        end
        idle_inputs();
        pause = 1'b0;
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_periodic();
        test_restart();
        test_start_stop();
        test_reset_mid();
`ifdef GAME_TIMER_PAUSE_EN
        test_pause();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
